// File: rtl/vga_video_out_pkg.sv
// Shared VGA timing defaults (640x480@60) and raster helpers.
package vga_video_out_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  // Total period of one axis, visible area plus porches and sync.
  function automatic int unsigned axis_total(input int unsigned disp, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return disp + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_video_out_if.sv
// Generator-facing and monitor-facing signals of the VGA output stage.
interface vga_video_out_if
  import vga_video_out_pkg::*;
#(
  parameter int unsigned RGB_W = 12
) ();

  logic [RGB_W-1:0] rgb_in;
  logic             p_tick;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             video_on;
  logic             frame_end;
  logic             hsync;
  logic             vsync;
  logic [RGB_W-1:0] rgb;

  modport master (
    input  rgb_in,
    output p_tick, pixel_x, pixel_y, video_on, frame_end, hsync, vsync, rgb
  );

  modport slave (
    output rgb_in,
    input  p_tick, pixel_x, pixel_y, video_on, frame_end, hsync, vsync, rgb
  );

endinterface

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH enabled shift register with per-bit reset value; DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int unsigned          WIDTH   = 1,
  parameter int unsigned          DEPTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en};
    assign dout      = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d = stage_q;
      if (en) begin
        stage_d[0] = din;
        for (int i = 1; i < int'(DEPTH); i++) stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_video_out.sv
// VGA output stage: pixel enable, raster counters, sync generation and
// pipeline-matched delay of sync/blank so colour stays pixel-aligned.
module vga_video_out
  import vga_video_out_pkg::*;
#(
  parameter int unsigned H_DISPLAY  = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_DISPLAY  = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned PIPE_DEPTH = 1,
  parameter int unsigned RGB_W      = 12,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  vga_video_out_if.master vif
);

  localparam int unsigned H_TOTAL  = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL  = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_FIRST = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_LAST  = H_DISPLAY + H_FRONT + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_LAST  = V_DISPLAY + V_FRONT + V_SYNC - 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  logic       p_tick_c;
  logic       h_last_c;
  logic       v_last_c;
  logic       video_on_c;
  logic       hs_act_c;
  logic       vs_act_c;
  logic [1:0] sync_raw_c;
  logic [1:0] sync_dly;
  logic       vo_dly;

  // Divider, raster counters and undelayed raster decodes.
  always_comb begin
    p_tick_c   = (div_q == DIV_W'(CLK_DIV - 1));
    h_last_c   = (h_q == CNT_W'(H_TOTAL - 1));
    v_last_c   = (v_q == CNT_W'(V_TOTAL - 1));
    video_on_c = (h_q < CNT_W'(H_DISPLAY)) && (v_q < CNT_W'(V_DISPLAY));
    hs_act_c   = (h_q >= CNT_W'(HS_FIRST)) && (h_q <= CNT_W'(HS_LAST));
    vs_act_c   = (v_q >= CNT_W'(VS_FIRST)) && (v_q <= CNT_W'(VS_LAST));
    sync_raw_c = {hs_act_c ? SYNC_POL : ~SYNC_POL, vs_act_c ? SYNC_POL : ~SYNC_POL};

    div_d = p_tick_c ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    rgb_d = rgb_q;
    if (p_tick_c) begin
      h_d   = h_last_c ? '0 : h_q + CNT_W'(1);
      rgb_d = vo_dly ? vif.rgb_in : '0;
      if (h_last_c) v_d = v_last_c ? '0 : v_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      rgb_q <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      rgb_q <= rgb_d;
    end
  end

  // Sync runs the full pipeline; blank stops one short so the rgb register is the last stage.
  vga_delay_line #(
    .WIDTH   (2),
    .DEPTH   (PIPE_DEPTH),
    .RST_VAL ({~SYNC_POL, ~SYNC_POL})
  ) u_sync_dly (
    .clk  (clk),
    .rst  (reset),
    .en   (p_tick_c),
    .din  (sync_raw_c),
    .dout (sync_dly)
  );

  vga_delay_line #(
    .WIDTH   (1),
    .DEPTH   (PIPE_DEPTH - 1),
    .RST_VAL (1'b0)
  ) u_vo_dly (
    .clk  (clk),
    .rst  (reset),
    .en   (p_tick_c),
    .din  (video_on_c),
    .dout (vo_dly)
  );

  assign vif.p_tick    = p_tick_c;
  assign vif.pixel_x   = h_q;
  assign vif.pixel_y   = v_q;
  assign vif.video_on  = video_on_c;
  assign vif.frame_end = p_tick_c && h_last_c && v_last_c;
  assign vif.hsync     = sync_dly[1];
  assign vif.vsync     = sync_dly[0];
  assign vif.rgb       = rgb_q;

endmodule

// File: doc/vga_video_out.md
# vga_video_out

Parametrised VGA output stage that generates the pixel-clock enable, raster counters and sync pulses, and re-aligns the graphics generator's colour output with them. It replaces the fixed 640x480 sync unit plus one-stage rgb buffer in the top level. It adds programmable timing, sync polarity and colour width. It also delays sync/blank to match a graphics pipeline of any depth, so deeper renderers stay pixel-aligned.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_DISPLAY, 480, visible lines per frame
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- CLK_DIV, 2, clk cycles per pixel; legal range is 1 or more
- PIPE_DEPTH, 1, pixel periods from counter value to the output register; legal range is 1 or more
- RGB_W, 12, colour bus width
- SYNC_POL, 0, active sync level (0 means active-low)
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- rgb_in  in  RGB_W  colour from graphics generator
- p_tick  out  1  pixel enable, one clk wide
- pixel_x, pixel_y  out  10  current raster counters; H_TOTAL and V_TOTAL must each be 1024 or less
- video_on  out  1  counters inside the visible area (undelayed, for the generator)
- frame_end  out  1  one-clk pulse on the last pixel of the frame
- hsync, vsync  out  1  delayed syncs
- rgb  out  RGB_W  delayed, blanked colour

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK. V_TOTAL is defined the same way.
- Divider counts 0..CLK_DIV-1. p_tick = (div == CLK_DIV-1), which is combinational from the register. When CLK_DIV=1, p_tick is constantly 1.
- On p_tick, h_count increments. It wraps from H_TOTAL-1 to 0; on that wrap v_count increments, and v_count wraps from V_TOTAL-1 to 0.
- pixel_x = h_count and pixel_y = v_count. video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
- raw_hsync is active for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]. raw_vsync is defined the same way on v.
- Active level is SYNC_POL. Inactive level is !SYNC_POL.
- frame_end = p_tick && h == H_TOTAL-1 && v == V_TOTAL-1.
- Delay line, advanced only on p_tick:
  - raw_hsync and raw_vsync pass through PIPE_DEPTH stages.
  - video_on passes through PIPE_DEPTH-1 stages, giving vo_d.
  - The final rgb register captures (vo_d ? rgb_in : 0) on p_tick.
- Contract with the generator: on the p_tick in which counters show (x,y), rgb_in must hold the colour for the coordinate shown PIPE_DEPTH-1 pixel periods earlier. PIPE_DEPTH=1 means a combinational generator.
- Reset drives the following, immediately and without a clk edge:
  - div, h_count and v_count go to 0.
  - All sync stages, and hsync/vsync, go to the inactive level.
  - All video_on stages go to 0, and rgb goes to 0.
  - video_on = 1 during reset, because the counters are at (0,0).
- No mid-frame parameter changes: parameters are static.

## Timing
- hsync, vsync and rgb change only on clk edges where p_tick=1. Between those edges they hold for CLK_DIV clks.
- Output latency is PIPE_DEPTH pixel periods behind the counters. hsync's active edge appears at the p_tick edge ending pixel H_DISPLAY+H_FRONT+PIPE_DEPTH-1.
- After reset deassertion, the first p_tick occurs on clk cycle CLK_DIV, counting from 1.
- Line period is H_TOTAL*CLK_DIV clks. Frame period is H_TOTAL*V_TOTAL*CLK_DIV clks.
- Simultaneous h wrap and v wrap (frame_end) returns both counters to 0 on the same edge.
- Outputs are sync-delay-line registers, so there are no combinational paths to hsync, vsync or rgb.

## Structure
- Shared timing include holds the default 640x480@60 constants, plus H_TOTAL/V_TOTAL derivation macros. Any future 800x600 set goes in the same include.
- One sub-module, vga_delay_line: a WIDTH x DEPTH shift register with enable and a per-bit reset value. It is instantiated for {hsync, vsync} and for video_on, and handles DEPTH=0 as a pass-through.

## Test plan
- **Reset release (defaults):** p_tick pulses every 2nd clk, starting on clk 2. hsync=vsync=1 and rgb=0 until the first visible pixel reaches the output.
- **Line timing:** hsync low for exactly 96 p_ticks. Its falling edge comes 656 p_ticks after line start plus PIPE_DEPTH-1. Line length is 800 p_ticks (1600 clks).
- **Frame timing:** vsync low for 2 lines starting on line 490. frame_end pulses once every 420000 p_ticks, only at (799,524).
- **Blanking:** with rgb_in=12'hFFF held, rgb=FFF for 640 ticks per visible line and 0 elsewhere, including lines 480-524.
- **PIPE_DEPTH=3, CLK_DIV=1, SYNC_POL=1:**
  - Generator model registers f(x)=x[11:0] twice.
  - rgb shows 0..639 in order, and the rgb value of 639 precedes blank by exactly one tick.
  - hsync rises at the p_tick edge ending pixel 658.
- **Async reset mid-line:** assert at h=300 without a clk edge. Outputs go to reset values immediately, and counting restarts from (0,0).
